// File: rtl/eh2_dec_trigger_seq.sv
// Decode-stage trigger unit: per-thread PC/NAPOT triggers with hit-count thresholds and pairwise chaining.
// Match vectors are registered (one cycle after the D-stage hit); no backpressure, slots arrive stall-qualified.
module eh2_dec_trigger_seq #(
  parameter int NUM_THREADS = 2,
  parameter int NUM_TRIG    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   dec_i0_valid_d,
  input  logic                                   dec_i0_tid_d,
  input  logic [31:1]                            dec_i0_pc_d,
  input  logic                                   dec_i1_valid_d,
  input  logic                                   dec_i1_tid_d,
  input  logic [31:1]                            dec_i1_pc_d,
  input  logic [NUM_THREADS*NUM_TRIG-1:0]        trig_execute,
  input  logic [NUM_THREADS*NUM_TRIG-1:0]        trig_m,
  input  logic [NUM_THREADS*NUM_TRIG-1:0]        trig_napot,
  input  logic [NUM_THREADS*NUM_TRIG-1:0]        trig_chain,
  input  logic [NUM_THREADS*NUM_TRIG*32-1:0]     trig_tdata2,
  input  logic [NUM_THREADS*NUM_TRIG*CNT_W-1:0]  trig_thresh,
  input  logic [NUM_THREADS*NUM_TRIG-1:0]        trig_cfg_upd,
  input  logic [NUM_THREADS-1:0]                 dec_tlu_flush,
  output logic [NUM_TRIG-1:0]                    dec_i0_trigger_match_e1,
  output logic [NUM_TRIG-1:0]                    dec_i1_trigger_match_e1,
  output logic [NUM_THREADS*NUM_TRIG-1:0]        trig_armed
);

  localparam int T  = NUM_THREADS;
  localparam int N  = NUM_TRIG;
  localparam int TN = T * N;
  localparam int CW = CNT_W + 2;
  localparam logic [CW-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] cnt_q [TN];
  logic [CNT_W-1:0] cnt_d [TN];
  logic [TN-1:0]    arm_q, arm_d;
  logic [TN-1:0]    hit0, hit1, fire0, fire1;
  logic [N-1:0]     out0, out1;
  logic [N-1:0]     match0_q, match1_q;
  logic             unused_chain_odd;

  // NAPOT: every bit up to and including the lowest zero of the pattern is a don't-care.
  function automatic logic pc_match(input logic [31:0] data, input logic [31:0] pat, input logic napot);
    logic [31:0] care;
    logic        ones;
    care = '1;
    ones = 1'b1;
    if (napot && !(&pat)) begin
      for (int b = 0; b < 32; b++) begin
        if (ones) care[b] = 1'b0;
        ones = ones & pat[b];
      end
    end
    return ((data ^ pat) & care) == 32'd0;
  endfunction

  always_comb begin
    hit0 = '0;
    hit1 = '0;
    for (int t = 0; t < T; t++) begin
      for (int i = 0; i < N; i++) begin
        hit0[t*N+i] = dec_i0_valid_d & (int'(dec_i0_tid_d) == t) & trig_execute[t*N+i] & trig_m[t*N+i] &
                      pc_match({dec_i0_pc_d, trig_tdata2[(t*N+i)*32]}, trig_tdata2[(t*N+i)*32 +: 32],
                               trig_napot[t*N+i]);
        hit1[t*N+i] = dec_i1_valid_d & (int'(dec_i1_tid_d) == t) & trig_execute[t*N+i] & trig_m[t*N+i] &
                      pc_match({dec_i1_pc_d, trig_tdata2[(t*N+i)*32]}, trig_tdata2[(t*N+i)*32 +: 32],
                               trig_napot[t*N+i]);
      end
    end
  end

  // i0 is older: its fire restarts the count before i1's hit is added.
  always_comb begin
    logic [CW-1:0] thr, c_a, c_b;
    thr   = '0;
    c_a   = '0;
    c_b   = '0;
    fire0 = '0;
    fire1 = '0;
    for (int k = 0; k < TN; k++) begin
      thr = (trig_thresh[k*CNT_W +: CNT_W] <= CNT_W'(1)) ? CW'(1) : CW'(trig_thresh[k*CNT_W +: CNT_W]);
      fire0[k] = hit0[k] & ((CW'(cnt_q[k]) + CW'(1)) >= thr);
      c_a = fire0[k] ? '0 : CW'(cnt_q[k]) + CW'(hit0[k]);
      fire1[k] = hit1[k] & ((c_a + CW'(1)) >= thr);
      c_b = fire1[k] ? '0 : c_a + CW'(hit1[k]);
      if (trig_cfg_upd[k])    cnt_d[k] = '0;
      else if (c_b > CNT_MAX) cnt_d[k] = '1;
      else                    cnt_d[k] = c_b[CNT_W-1:0];
    end
  end

  // Chained pair: per slot, trigger i+1 consumes the arm before trigger i can set it again.
  always_comb begin
    logic a1, a2;
    a1    = 1'b0;
    a2    = 1'b0;
    out0  = '0;
    out1  = '0;
    arm_d = '0;
    for (int t = 0; t < T; t++) begin
      for (int i = 0; i < N; i += 2) begin
        if (trig_chain[t*N+i]) begin
          a1 = (arm_q[t*N+i+1] & ~fire0[t*N+i+1]) | fire0[t*N+i];
          a2 = (a1 & ~fire1[t*N+i+1]) | fire1[t*N+i];
          out0[i+1] = out0[i+1] | (fire0[t*N+i+1] & arm_q[t*N+i+1]);
          out1[i+1] = out1[i+1] | (fire1[t*N+i+1] & a1);
          arm_d[t*N+i+1] = a2 & ~dec_tlu_flush[t] & ~trig_cfg_upd[t*N+i+1];
        end else begin
          out0[i]   = out0[i]   | fire0[t*N+i];
          out0[i+1] = out0[i+1] | fire0[t*N+i+1];
          out1[i]   = out1[i]   | fire1[t*N+i];
          out1[i+1] = out1[i+1] | fire1[t*N+i+1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q    <= '0;
      match0_q <= '0;
      match1_q <= '0;
      for (int k = 0; k < TN; k++) cnt_q[k] <= '0;
    end else begin
      arm_q    <= arm_d;
      match0_q <= out0;
      match1_q <= out1;
      for (int k = 0; k < TN; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    unused_chain_odd = 1'b0;
    for (int k = 1; k < TN; k += 2) unused_chain_odd = unused_chain_odd ^ trig_chain[k];
  end

  assign dec_i0_trigger_match_e1 = match0_q;
  assign dec_i1_trigger_match_e1 = match1_q;
  assign trig_armed              = arm_q;

endmodule

// File: tb/tb_eh2_dec_trigger_seq.sv
// Scoreboard bench: the driver queues hand-computed expectations, a negedge monitor compares them.
module tb_eh2_dec_trigger_seq;
  localparam int T  = 2;
  localparam int N  = 4;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              dec_i0_valid_d, dec_i0_tid_d, dec_i1_valid_d, dec_i1_tid_d;
  logic [31:1]       dec_i0_pc_d, dec_i1_pc_d;
  logic [T*N-1:0]    trig_execute, trig_m, trig_napot, trig_chain, trig_cfg_upd;
  logic [T*N*32-1:0] trig_tdata2;
  logic [T*N*CW-1:0] trig_thresh;
  logic [T-1:0]      dec_tlu_flush;
  logic [N-1:0]      dec_i0_trigger_match_e1, dec_i1_trigger_match_e1;
  logic [T*N-1:0]    trig_armed;

  always #5 clk = ~clk;

  eh2_dec_trigger_seq #(.NUM_THREADS(T), .NUM_TRIG(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .dec_i0_valid_d(dec_i0_valid_d), .dec_i0_tid_d(dec_i0_tid_d), .dec_i0_pc_d(dec_i0_pc_d),
    .dec_i1_valid_d(dec_i1_valid_d), .dec_i1_tid_d(dec_i1_tid_d), .dec_i1_pc_d(dec_i1_pc_d),
    .trig_execute(trig_execute), .trig_m(trig_m), .trig_napot(trig_napot), .trig_chain(trig_chain),
    .trig_tdata2(trig_tdata2), .trig_thresh(trig_thresh), .trig_cfg_upd(trig_cfg_upd),
    .dec_tlu_flush(dec_tlu_flush),
    .dec_i0_trigger_match_e1(dec_i0_trigger_match_e1),
    .dec_i1_trigger_match_e1(dec_i1_trigger_match_e1),
    .trig_armed(trig_armed)
  );

  typedef struct packed {
    logic [31:0]    due;
    logic [N-1:0]   i0;
    logic [N-1:0]   i1;
    logic [T*N-1:0] arm;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() != 0 && int'(exp_q[0].due) <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (int'(e.due) != cyc)
        $display("FAIL %s: expectation expired, due cyc %0d, checked at cyc %0d", nm, e.due, cyc);
      else if (dec_i0_trigger_match_e1 === e.i0 && dec_i1_trigger_match_e1 === e.i1 &&
               trig_armed === e.arm)
        passes++;
      else
        $display("FAIL %s: got i0=%b i1=%b armed=%b (cyc %0d), want i0=%b i1=%b armed=%b (cyc %0d)",
                 nm, dec_i0_trigger_match_e1, dec_i1_trigger_match_e1, trig_armed, cyc,
                 e.i0, e.i1, e.arm, e.due);
    end
  end

  task automatic set_trig(input int t, input int i, input bit ex, input bit mm, input bit nap, input bit ch,
                          input logic [31:0] td, input logic [CW-1:0] th);
    int k;
    k = t*N + i;
    trig_execute[k] = ex;
    trig_m[k]       = mm;
    trig_napot[k]   = nap;
    trig_chain[k]   = ch;
    trig_tdata2[k*32 +: 32] = td;
    trig_thresh[k*CW +: CW] = th;
  endtask

  task automatic step(input string nm, input bit v0, input bit t0, input logic [31:0] p0,
                      input bit v1, input bit t1, input logic [31:0] p1,
                      input logic [N-1:0] e0, input logic [N-1:0] e1, input logic [T*N-1:0] ea);
    exp_t e;
    dec_i0_valid_d = v0;
    dec_i0_tid_d   = t0;
    dec_i0_pc_d    = p0[31:1];
    dec_i1_valid_d = v1;
    dec_i1_tid_d   = t1;
    dec_i1_pc_d    = p1[31:1];
    e.due = 32'(cyc + 1);
    e.i0  = e0;
    e.i1  = e1;
    e.arm = ea;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    dec_i0_valid_d = 1'b0;
    dec_i1_valid_d = 1'b0;
  endtask

  task automatic idle(input string nm, input logic [N-1:0] e0, input logic [N-1:0] e1,
                      input logic [T*N-1:0] ea);
    step(nm, 0, 0, 32'h0, 0, 0, 32'h0, e0, e1, ea);
  endtask

  task automatic cfg_pulse(input string nm);
    trig_cfg_upd = '1;
    idle(nm, 4'b0000, 4'b0000, 8'h00);
    trig_cfg_upd = '0;
  endtask

  initial begin
    rst = 1'b1;
    dec_i0_valid_d = 0; dec_i0_tid_d = 0; dec_i0_pc_d = '0;
    dec_i1_valid_d = 0; dec_i1_tid_d = 0; dec_i1_pc_d = '0;
    trig_execute = '0; trig_m = '0; trig_napot = '0; trig_chain = '0;
    trig_tdata2 = '0; trig_thresh = '0; trig_cfg_upd = '0; dec_tlu_flush = '0;
    @(posedge clk);
    #1;
    checks++;
    if (dec_i0_trigger_match_e1 !== '0 || dec_i1_trigger_match_e1 !== '0 || trig_armed !== '0)
      $display("FAIL reset_state: i0=%b i1=%b armed=%b, want all zero",
               dec_i0_trigger_match_e1, dec_i1_trigger_match_e1, trig_armed);
    else
      passes++;
    idle("reset", 4'b0000, 4'b0000, 8'h00);
    idle("reset_hold", 4'b0000, 4'b0000, 8'h00);
    rst = 1'b0;

    // Exact match, threshold 0: every hit fires for one cycle.
    set_trig(0, 0, 1, 1, 0, 0, 32'h8000_0100, 8'd0);
    cfg_pulse("cfg_exact");
    step("exact_i0",        1, 0, 32'h8000_0100, 0, 0, 32'h0,         4'b0001, 4'b0000, 8'h00);
    idle("exact_one_cycle",                                          4'b0000, 4'b0000, 8'h00);
    step("exact_i1",        0, 0, 32'h0,         1, 0, 32'h8000_0100, 4'b0000, 4'b0001, 8'h00);
    step("exact_both",      1, 0, 32'h8000_0100, 1, 0, 32'h8000_0100, 4'b0001, 4'b0001, 8'h00);
    step("exact_off_by_2",  1, 0, 32'h8000_0102, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);
    step("exact_wrong_tid", 1, 1, 32'h8000_0100, 1, 1, 32'h8000_0100, 4'b0000, 4'b0000, 8'h00);

    // NAPOT over 0x8000_0000..0x8000_01FF, threshold 3.
    set_trig(0, 2, 1, 1, 1, 0, 32'h8000_00FF, 8'd3);
    cfg_pulse("cfg_napot");
    step("napot_h1",        1, 0, 32'h8000_0010, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);
    step("napot_h2",        1, 0, 32'h8000_0020, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);
    step("napot_outside",   1, 0, 32'h8000_0200, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);
    step("napot_h3_fire",   1, 0, 32'h8000_0030, 0, 0, 32'h0,         4'b0100, 4'b0000, 8'h00);
    step("napot_pair_cnt2", 1, 0, 32'h8000_0040, 1, 0, 32'h8000_0050, 4'b0000, 4'b0000, 8'h00);
    step("napot_refire",    1, 0, 32'h8000_0060, 0, 0, 32'h0,         4'b0100, 4'b0000, 8'h00);
    step("napot_pair2",     1, 0, 32'h8000_0070, 1, 0, 32'h8000_0080, 4'b0000, 4'b0000, 8'h00);
    step("napot_i0_fire",   1, 0, 32'h8000_0090, 1, 0, 32'h8000_00A0, 4'b0100, 4'b0000, 8'h00);
    step("napot_i1_cnt2",   0, 0, 32'h0,         1, 0, 32'h8000_00B0, 4'b0000, 4'b0000, 8'h00);
    step("napot_carry",     1, 0, 32'h8000_00C0, 0, 0, 32'h0,         4'b0100, 4'b0000, 8'h00);

    // Chain: trigger 0 arms trigger 1 on thread 0.
    set_trig(0, 0, 1, 1, 0, 1, 32'h8000_0100, 8'd0);
    set_trig(0, 1, 1, 1, 0, 0, 32'h8000_0200, 8'd0);
    set_trig(0, 2, 0, 0, 0, 0, 32'h0, 8'd0);
    cfg_pulse("cfg_chain");
    step("chain_arm",       1, 0, 32'h8000_0100, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h02);
    idle("chain_hold1",                                              4'b0000, 4'b0000, 8'h02);
    idle("chain_hold2",                                              4'b0000, 4'b0000, 8'h02);
    step("chain_fire",      1, 0, 32'h8000_0200, 0, 0, 32'h0,         4'b0010, 4'b0000, 8'h00);
    idle("chain_after",                                              4'b0000, 4'b0000, 8'h00);
    step("chain_unarmed",   1, 0, 32'h8000_0200, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);
    step("chain_i0t1_i1t0", 1, 0, 32'h8000_0200, 1, 0, 32'h8000_0100, 4'b0000, 4'b0000, 8'h02);
    dec_tlu_flush = 2'b01;
    idle("chain_flush",                                              4'b0000, 4'b0000, 8'h00);
    dec_tlu_flush = 2'b00;
    step("chain_i0t0_i1t1", 1, 0, 32'h8000_0100, 1, 0, 32'h8000_0200, 4'b0000, 4'b0010, 8'h00);

    // Flush and thread isolation.
    set_trig(1, 0, 1, 1, 0, 1, 32'h8000_0100, 8'd0);
    set_trig(1, 1, 1, 1, 0, 0, 32'h8000_0200, 8'd0);
    cfg_pulse("cfg_thread1");
    step("arm_both_threads", 1, 0, 32'h8000_0100, 1, 1, 32'h8000_0100, 4'b0000, 4'b0000, 8'h22);
    dec_tlu_flush = 2'b01;
    idle("flush_t0_only",                                             4'b0000, 4'b0000, 8'h20);
    dec_tlu_flush = 2'b00;
    step("t0_after_flush",   1, 0, 32'h8000_0200, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h20);
    step("t1_fire",          0, 0, 32'h0,         1, 1, 32'h8000_0200, 4'b0000, 4'b0010, 8'h00);
    dec_tlu_flush = 2'b01;
    step("flush_blocks_arm", 1, 0, 32'h8000_0100, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);
    dec_tlu_flush = 2'b00;

    // Config update with a same-cycle hit clears the count; threshold 4.
    set_trig(0, 2, 1, 1, 1, 0, 32'h8000_00FF, 8'd4);
    cfg_pulse("cfg_thr4");
    step("thr4_cnt2",       1, 0, 32'h8000_0010, 1, 0, 32'h8000_0020, 4'b0000, 4'b0000, 8'h00);
    trig_cfg_upd = 8'h04;
    step("upd_with_hit",    1, 0, 32'h8000_0030, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);
    trig_cfg_upd = '0;
    step("thr4_pair",       1, 0, 32'h8000_0040, 1, 0, 32'h8000_0050, 4'b0000, 4'b0000, 8'h00);
    step("thr4_cnt3",       1, 0, 32'h8000_0060, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);
    step("thr4_fire",       1, 0, 32'h8000_0070, 0, 0, 32'h0,         4'b0100, 4'b0000, 8'h00);

    // Reset in the middle of an armed chain and a partial count.
    step("pre_rst_arm",     1, 0, 32'h8000_0100, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h02);
    step("pre_rst_cnt3",    1, 0, 32'h8000_0010, 1, 0, 32'h8000_0020, 4'b0000, 4'b0000, 8'h02);
    rst = 1'b1;
    step("rst_mid",         1, 0, 32'h8000_0100, 1, 0, 32'h8000_0200, 4'b0000, 4'b0000, 8'h00);
    rst = 1'b0;
    step("post_rst_no_arm", 1, 0, 32'h8000_0200, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);
    step("post_rst_cnt1",   1, 0, 32'h8000_0010, 0, 0, 32'h0,         4'b0000, 4'b0000, 8'h00);

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL pending: %0d expectation(s) never checked, first %s", exp_q.size(), name_q[0]);
    else
      passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
